// File: rtl/clkdiv_ctrl_pkg.sv
// Shared constants and types for the two-channel clock-divider controller.
package clkdiv_ctrl_pkg;

    // Default width of every divide-ratio field.
    localparam int DIV_W_DEF = 8;

    // Half-periods (in clkin cycles) loaded at reset; 0 leaves the channel off.
    localparam int DIV1_RST_DEF = 1;
    localparam int DIV2_RST_DEF = 2;

    // Encoding of cfg_sel on the config port.
    typedef enum logic {
        SEL_CH1 = 1'b0,
        SEL_CH2 = 1'b1
    } cfg_sel_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divided-clock channel: half-period counter, output flop, active and
// pending ratio, and the logic that swaps in a new ratio only on a falling
// boundary so the output never emits a runt high pulse.
module clkdiv_chan #(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 1
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             pending,
    output logic             done,
    output logic             clk_out
);

    logic [DIV_W-1:0] active_d;
    logic [DIV_W-1:0] pend_d;
    logic [DIV_W-1:0] cnt;
    logic             running;
    logic             last;
    logic             apply;

    // Locate the end of the current half-period and decide whether a pending ratio lands this cycle.
    always_comb begin
        running = (active_d != '0);
        last    = running && (cnt == active_d - DIV_W'(1));
        apply   = pending && (!running || (last && clk_out));
    end

    // Counter, output and active ratio; a new ratio restarts the channel low with a cleared counter.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            active_d <= DIV_W'(RST_DIV);
            cnt      <= '0;
            clk_out  <= 1'b0;
        end else if (apply) begin
            active_d <= pend_d;
            cnt      <= '0;
            clk_out  <= 1'b0;
        end else if (running) begin
            if (last) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end else begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end
    end

    // Pending-ratio holding register and the one-cycle done pulse following an apply.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            pend_d  <= '0;
            done    <= 1'b0;
        end else begin
            done <= apply;
            if (apply) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
                pend_d  <= load_div;
            end
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Two-channel programmable clock divider. Holds only the config decode and
// the ready mux; each channel does its own counting and ratio swapping.
// reset_n is expected to be release-synchronised to clkin upstream.
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV1_RST = DIV1_RST_DEF,
    parameter int DIV2_RST = DIV2_RST_DEF
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [1:0]       cfg_done,
    output logic             clkout1,
    output logic             clkout2
);

    logic [1:0] pend;
    logic [1:0] load;

    // A channel can take a new ratio only when nothing is already waiting for it; route the handshake to the selected channel.
    always_comb begin
        cfg_ready = ~pend[cfg_sel];
        load[0]   = cfg_valid && cfg_ready && (cfg_sel == SEL_CH1);
        load[1]   = cfg_valid && cfg_ready && (cfg_sel == SEL_CH2);
    end

    clkdiv_chan #(
        .DIV_W   (DIV_W),
        .RST_DIV (DIV1_RST)
    ) u_chan1 (
        .clkin    (clkin),
        .reset_n  (reset_n),
        .load     (load[0]),
        .load_div (cfg_div),
        .pending  (pend[0]),
        .done     (cfg_done[0]),
        .clk_out  (clkout1)
    );

    clkdiv_chan #(
        .DIV_W   (DIV_W),
        .RST_DIV (DIV2_RST)
    ) u_chan2 (
        .clkin    (clkin),
        .reset_n  (reset_n),
        .load     (load[1]),
        .load_div (cfg_div),
        .pending  (pend[1]),
        .done     (cfg_done[1]),
        .clk_out  (clkout2)
    );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Testbench for clkdiv_ctrl: directed scenarios followed by random config
// traffic, all compared every cycle against a phase-based reference model.
module tb_clkdiv_ctrl;

    logic       clkin;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_sel;
    logic [7:0] cfg_div;
    logic [1:0] cfg_done;
    logic       clkout1;
    logic       clkout2;

    int n_checks;
    int n_pass;

    // Reference model: each channel is described by its half-period d and
    // the number of clkin edges k (mod 2d) since its current segment began.
    // The output is high during the second half of each 2d-cycle period.
    int         md  [2];
    int         mk  [2];
    int         mpd [2];
    bit         mp  [2];
    logic [1:0] mdone;

    clkdiv_ctrl dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_done  (cfg_done),
        .clkout1   (clkout1),
        .clkout2   (clkout2)
    );

    initial clkin = 1'b0;
    always #10 clkin = ~clkin;

    function automatic logic model_out(input int ch);
        return (md[ch] > 0) && (mk[ch] >= md[ch]);
    endfunction

    task automatic model_reset();
        md[0] = 1;
        md[1] = 2;
        for (int c = 0; c < 2; c++) begin
            mk[c]  = 0;
            mpd[c] = 0;
            mp[c]  = 1'b0;
        end
        mdone = 2'b00;
    endtask

    // Advance the model over one clkin rising edge with the inputs seen at that edge.
    task automatic model_step(input logic v, input logic s, input logic [7:0] dv);
        logic       acc;
        logic       app;
        logic [1:0] nd;
        acc = v && !mp[s];
        nd  = 2'b00;
        for (int c = 0; c < 2; c++) begin
            app = 1'b0;
            if (mp[c])
                app = (md[c] == 0) || (mk[c] + 1 == 2 * md[c]);
            nd[c] = app;
            if (app) begin
                md[c] = mpd[c];
                mk[c] = 0;
                mp[c] = 1'b0;
            end else if (md[c] > 0) begin
                mk[c] = (mk[c] + 1) % (2 * md[c]);
            end else begin
                mk[c] = 0;
            end
            if (acc && (int'(s) == c)) begin
                mp[c]  = 1'b1;
                mpd[c] = int'(dv);
            end
        end
        mdone = nd;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic note_timeout(input string tag);
        n_checks++;
        $error("[TB] FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic check_output();
        check("clkout1", {1'b0, clkout1}, {1'b0, model_out(0)});
        check("clkout2", {1'b0, clkout2}, {1'b0, model_out(1)});
        check("cfg_done", cfg_done, mdone);
    endtask

    // One clkin cycle: entered and left just after a falling edge.
    task automatic apply_stimulus(input logic v, input logic s, input logic [7:0] dv);
        check_output();
        cfg_valid = v;
        cfg_sel   = s;
        cfg_div   = dv;
        #1;
        check("cfg_ready", {1'b0, cfg_ready}, {1'b0, !mp[s]});
        @(posedge clkin);
        model_step(v, s, dv);
        @(negedge clkin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b0, 8'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while ((mp[0] || mp[1]) && i < budget) begin
            apply_stimulus(1'b0, 1'b0, 8'd0);
            i++;
        end
        if (mp[0] || mp[1])
            note_timeout(tag);
    endtask

    initial begin
        int         i;
        logic       rv;
        logic       rs;
        logic [7:0] rd;

        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 1'b0;
        cfg_div   = 8'd0;
        model_reset();

        // Reset state
        #5;
        check("rst_clkout1", {1'b0, clkout1}, 2'b00);
        check("rst_clkout2", {1'b0, clkout2}, 2'b00);
        check("rst_done", cfg_done, 2'b00);
        check("rst_ready", {1'b0, cfg_ready}, 2'b01);
        @(negedge clkin);
        @(negedge clkin);
        reset_n = 1'b1;
        $display("[TB] reset released at %0t", $time);

        // Reset ratios: ch0 period 2 cycles, ch1 period 4 cycles
        idle(10);

        // Reprogram ch0 to 3 while it is high
        i = 0;
        while (!model_out(0) && i < 4) begin
            idle(1);
            i++;
        end
        if (!model_out(0))
            note_timeout("wait_ch0_high");
        apply_stimulus(1'b1, 1'b0, 8'd3);
        idle(16);

        // Disable ch1, then re-enable with D = 5
        apply_stimulus(1'b1, 1'b1, 8'd0);
        wait_idle("ch1_disable", 20);
        idle(6);
        apply_stimulus(1'b1, 1'b1, 8'd5);
        idle(24);

        // Back-pressure on ch0 while ch1 is accepted independently
        wait_idle("pre_backpressure", 20);
        apply_stimulus(1'b1, 1'b0, 8'd200);
        apply_stimulus(1'b1, 1'b0, 8'd7);
        apply_stimulus(1'b1, 1'b1, 8'd2);
        i = 0;
        while (mp[0] && i < 20) begin
            apply_stimulus(1'b1, 1'b0, 8'd7);
            i++;
        end
        if (mp[0])
            note_timeout("ch0_200_apply");
        apply_stimulus(1'b1, 1'b0, 8'd7);
        wait_idle("ch0_7_apply", 500);
        idle(20);

        // Simultaneous apply: ch0 running at D = 4, ch1 off, both land on ch0's falling edge
        apply_stimulus(1'b1, 1'b0, 8'd4);
        apply_stimulus(1'b1, 1'b1, 8'd0);
        wait_idle("pre_simul", 40);
        i = 0;
        while (!(md[0] == 4 && mk[0] == 5) && i < 20) begin
            idle(1);
            i++;
        end
        if (!(md[0] == 4 && mk[0] == 5))
            note_timeout("simul_align");
        apply_stimulus(1'b1, 1'b0, 8'd4);
        apply_stimulus(1'b1, 1'b1, 8'd4);
        idle(1);
        check("simul_done", cfg_done, 2'b11);
        for (int c = 0; c < 16; c++) begin
            idle(1);
            check("in_phase", {1'b0, clkout1}, {1'b0, clkout2});
        end

        // Reset while ch0 has a pending ratio
        apply_stimulus(1'b1, 1'b0, 8'd9);
        cfg_valid = 1'b0;
        cfg_sel   = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_clkout1", {1'b0, clkout1}, 2'b00);
        check("midrst_clkout2", {1'b0, clkout2}, 2'b00);
        check("midrst_done", cfg_done, 2'b00);
        check("midrst_ready", {1'b0, cfg_ready}, 2'b01);
        model_reset();
        @(negedge clkin);
        reset_n = 1'b1;
        idle(12);

        // Largest legal ratio
        apply_stimulus(1'b1, 1'b1, 8'd255);
        wait_idle("ch1_255_apply", 20);
        idle(520);

        // Random config traffic
        for (int c = 0; c < 1500; c++) begin
            rv = ($urandom_range(0, 2) == 0);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                rd = 8'd255;
            else
                rd = 8'($urandom_range(0, 6));
            apply_stimulus(rv, rs, rd);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
